// File: rtl/ita_activation_pkg.sv
// Shared types and widths for the ITA activation stage.
// Build option: ITA_ACTIVATION_GELU_EN enables the integer GELU lanes.
package ita_package;

    localparam int unsigned WI                   = 8;
    localparam int unsigned EMS                  = 8;
    localparam int unsigned GELU_CONSTANTS_WIDTH = 16;
    localparam int unsigned TILE_LEN_WIDTH       = 16;

    typedef logic signed [WI-1:0] requant_t;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        RELU     = 2'd1,
        GELU     = 2'd2
    } activation_e;

    // Per-tile activation configuration, carried alongside each beat.
    typedef struct packed {
        activation_e                             activation;
        logic signed [GELU_CONSTANTS_WIDTH-1:0]  one;
        logic signed [GELU_CONSTANTS_WIDTH-1:0]  b;
        logic signed [GELU_CONSTANTS_WIDTH-1:0]  c;
        logic signed [EMS-1:0]                   eps_mult;
        logic [EMS-1:0]                          right_shift;
        logic [EMS-1:0]                          add;
    } act_cfg_t;

    // IDENTITY encodes as zero, so an all-zero struct is the reset config.
    localparam act_cfg_t ACT_CFG_RESET = '0;

    // A programmed tile length of zero means a single-beat tile.
    function automatic logic [TILE_LEN_WIDTH-1:0] eff_tile_len(
        input logic [TILE_LEN_WIDTH-1:0] len
    );
        return (len == '0) ? TILE_LEN_WIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/ita_activation_if.sv
// Valid/ready beat stream of requantized lanes with a last-beat marker.
interface ita_activation_if
    import ita_package::*;
#(
    parameter int unsigned N = 16
) ();

    logic                 valid;
    logic                 ready;
    requant_t [N-1:0]     data;
    logic                 last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/ita_activation_gelu.sv
// Single-lane integer GELU with round-half-away-from-zero requant and int8
// saturation. Purely combinational; the caller registers the result.
module ita_gelu
    import ita_package::*;
(
    input  requant_t                               data_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] one_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] b_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] c_i,
    input  logic signed [EMS-1:0]                  eps_mult_i,
    input  logic [EMS-1:0]                         right_shift_i,
    input  logic [EMS-1:0]                         add_i,
    output requant_t                               data_o
);

    // Wide enough that no intermediate overflows for any constant values.
    localparam int unsigned AW = 64;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-128);

    logic signed [AW-1:0] x_c, abs_c, nb_c, clip_c, t_c, erf_c;
    logic signed [AW-1:0] gelu_c, prod_c, rnd_c, sum_c;
    logic [AW-1:0]        mag_c, half_c, shr_c;

    // Polynomial erf approximation, scale, round, offset and saturate.
    always_comb begin
        x_c    = AW'(data_i);
        abs_c  = x_c[AW-1] ? -x_c : x_c;
        nb_c   = -AW'(b_i);
        clip_c = (abs_c > nb_c) ? nb_c : abs_c;
        t_c    = clip_c + AW'(b_i);
        erf_c  = t_c * t_c + AW'(c_i);
        if (x_c[AW-1]) begin
            erf_c = -erf_c;
        end
        gelu_c = x_c * (erf_c + AW'(one_i));
        prod_c = gelu_c * AW'(eps_mult_i);

        mag_c  = prod_c[AW-1] ? $unsigned(-prod_c) : $unsigned(prod_c);
        half_c = '0;
        shr_c  = mag_c;
        rnd_c  = prod_c;
        if (right_shift_i != '0) begin
            half_c    = '0;
            half_c[0] = 1'b1;
            half_c    = half_c << (right_shift_i - EMS'(1));
            shr_c     = (mag_c + half_c) >> right_shift_i;
            rnd_c     = prod_c[AW-1] ? -$signed(shr_c) : $signed(shr_c);
        end

        sum_c = rnd_c + $signed(AW'(add_i));
        if (sum_c > SAT_MAX) begin
            data_o = SAT_MAX[WI-1:0];
        end else if (sum_c < SAT_MIN) begin
            data_o = SAT_MIN[WI-1:0];
        end else begin
            data_o = sum_c[WI-1:0];
        end
    end

endmodule

// File: rtl/ita_activation.sv
// N-lane activation stage (identity / ReLU / optional integer GELU) with a
// two-register valid/ready pipeline and per-tile config snapshots.
// Build option: ITA_ACTIVATION_GELU_EN instantiates the ita_gelu lanes;
// without it, code GELU falls back to identity.
module ita_activation
    import ita_package::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    ita_activation_if.slave                        in_if,
    ita_activation_if.master                       out_if,
    input  logic [1:0]                             activation_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] one_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] b_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] c_i,
    input  logic signed [EMS-1:0]                  eps_mult_i,
    input  logic [EMS-1:0]                         right_shift_i,
    input  logic [EMS-1:0]                         add_i,
    input  logic [TILE_LEN_WIDTH-1:0]              tile_len_i,
    output logic                                   tile_done_o
);

    localparam int unsigned TLW = TILE_LEN_WIDTH;

    act_cfg_t             cfg_q, cfg_live_c, beat_cfg_c;
    logic [TLW-1:0]       len_q, beat_len_c, in_cnt_q, in_cnt_d;
    logic                 first_c, beat_last_c, in_fire_c;

    logic                 s1_valid_q, s1_last_q;
    requant_t [N-1:0]     s1_data_q;
    act_cfg_t             s1_cfg_q;

    logic                 s2_valid_q, s2_last_q;
    requant_t [N-1:0]     s2_data_q, act_c;

    logic                 s1_adv_c, s2_adv_c;
    logic                 unused_c;

    assign s2_adv_c  = ~s2_valid_q | out_if.ready;
    assign s1_adv_c  = ~s1_valid_q | s2_adv_c;
    assign in_fire_c = in_if.valid & s1_adv_c;

    // First beat of a tile uses the live config; later beats use the snapshot.
    always_comb begin
        cfg_live_c = '{activation:  activation_e'(activation_i),
                       one:         one_i,
                       b:           b_i,
                       c:           c_i,
                       eps_mult:    eps_mult_i,
                       right_shift: right_shift_i,
                       add:         add_i};
        first_c     = (in_cnt_q == '0);
        beat_cfg_c  = first_c ? cfg_live_c : cfg_q;
        beat_len_c  = first_c ? eff_tile_len(tile_len_i) : len_q;
        beat_last_c = (in_cnt_q == beat_len_c - TLW'(1));
        in_cnt_d    = in_cnt_q;
        if (in_fire_c) begin
            in_cnt_d = beat_last_c ? '0 : in_cnt_q + TLW'(1);
        end
    end

    // Tile position counter and per-tile config capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_cnt_q <= '0;
            cfg_q    <= ACT_CFG_RESET;
            len_q    <= TLW'(1);
        end else begin
            in_cnt_q <= in_cnt_d;
            if (in_fire_c && first_c) begin
                cfg_q <= cfg_live_c;
                len_q <= beat_len_c;
            end
        end
    end

    // Stage 1: raw beat, last tag and the config snapshot for this beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_cfg_q   <= ACT_CFG_RESET;
        end else if (s1_adv_c) begin
            s1_valid_q <= in_if.valid;
            if (in_if.valid) begin
                s1_data_q <= in_if.data;
                s1_last_q <= beat_last_c;
                s1_cfg_q  <= beat_cfg_c;
            end
        end
    end

`ifdef ITA_ACTIVATION_GELU_EN
    requant_t [N-1:0] gelu_c;

    for (genvar g = 0; g < N; g++) begin : g_gelu
        ita_gelu u_gelu (
            .data_i        (s1_data_q[g]),
            .one_i         (s1_cfg_q.one),
            .b_i           (s1_cfg_q.b),
            .c_i           (s1_cfg_q.c),
            .eps_mult_i    (s1_cfg_q.eps_mult),
            .right_shift_i (s1_cfg_q.right_shift),
            .add_i         (s1_cfg_q.add),
            .data_o        (gelu_c[g])
        );
    end
`endif

    // Per-lane activation selected by the stage-1 snapshot; code 3 is identity.
    always_comb begin
        act_c = s1_data_q;
        for (int i = 0; i < int'(N); i++) begin
            case (s1_cfg_q.activation)
                RELU:    act_c[i] = s1_data_q[i][WI-1] ? '0 : s1_data_q[i];
`ifdef ITA_ACTIVATION_GELU_EN
                GELU:    act_c[i] = gelu_c[i];
`endif
                default: act_c[i] = s1_data_q[i];
            endcase
        end
    end

    // Stage 2: activated beat and last tag, driving the output stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else if (s2_adv_c) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= act_c;
                s2_last_q <= s1_last_q;
            end
        end
    end

    assign in_if.ready  = s1_adv_c;
    assign out_if.valid = s2_valid_q;
    assign out_if.data  = s2_data_q;
    assign out_if.last  = s2_last_q;
    assign tile_done_o  = s2_valid_q & out_if.ready & s2_last_q;

    // Input last tag is not used; GELU fields are only consumed when enabled.
    assign unused_c = ^{in_if.last, s1_cfg_q};

endmodule

// File: tb/tb_ita_activation.sv
// Self-checking bench for ita_activation: directed steps plus a random phase,
// checked against a tile/activation reference model and an expected-beat queue.
module tb_ita_activation;
    import ita_package::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = N * WI;
    localparam int unsigned GW = GELU_CONSTANTS_WIDTH;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [1:0]                    activation_i;
    logic signed [GW-1:0]          one_i, b_i, c_i;
    logic signed [EMS-1:0]         eps_mult_i;
    logic [EMS-1:0]                right_shift_i, add_i;
    logic [15:0]                   tile_len_i;
    logic                          tile_done_o;

    ita_activation_if #(.N(N)) in_if ();
    ita_activation_if #(.N(N)) out_if ();

    ita_activation #(.N(N)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_if         (in_if),
        .out_if        (out_if),
        .activation_i  (activation_i),
        .one_i         (one_i),
        .b_i           (b_i),
        .c_i           (c_i),
        .eps_mult_i    (eps_mult_i),
        .right_shift_i (right_shift_i),
        .add_i         (add_i),
        .tile_len_i    (tile_len_i),
        .tile_done_o   (tile_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t           exp_q[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             n_acc = 0;
    int             m_cnt = 0, m_len = 1, m_act = 0;
    int             m_one = 0, m_b = 0, m_c = 0, m_eps = 0, m_sh = 0, m_add = 0;
    logic [DW-1:0]  last_out = '0;
    bit             stall_q = 1'b0;
    logic [DW-1:0]  stall_data;
    logic           stall_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lane(input logic [DW-1:0] d, input int i);
        return int'($signed(d[i*WI +: WI]));
    endfunction

    function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [DW-1:0] r;
        r[0*WI +: WI] = WI'(a);
        r[1*WI +: WI] = WI'(b);
        r[2*WI +: WI] = WI'(c);
        r[3*WI +: WI] = WI'(d);
        return r;
    endfunction

`ifdef ITA_ACTIVATION_GELU_EN
    function automatic int gelu_model(input int x);
        longint ax, clip, t, erf, g, p, r, a;
        ax   = (x < 0) ? -longint'(x) : longint'(x);
        clip = (ax > -longint'(m_b)) ? -longint'(m_b) : ax;
        t    = clip + m_b;
        erf  = t * t + m_c;
        if (x < 0) erf = -erf;
        g = longint'(x) * (erf + m_one);
        p = g * m_eps;
        if (m_sh == 0) begin
            r = p;
        end else begin
            a = (p < 0) ? -p : p;
            a = (a + (longint'(1) <<< (m_sh - 1))) >>> m_sh;
            r = (p < 0) ? -a : a;
        end
        r = r + m_add;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction
`endif

    function automatic int act_model(input int x);
        if (m_act == 1) return (x < 0) ? 0 : x;
`ifdef ITA_ACTIVATION_GELU_EN
        if (m_act == 2) return gelu_model(x);
`endif
        return x;
    endfunction

    // One clock: inputs already driven after a falling edge; sample, model, advance.
    task automatic tick();
        bit   in_fire, out_fire;
        exp_t e;
        #1;
        if (rst_i) begin
            exp_q.delete();
            m_cnt   = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", out_if.valid, 1);
                check("stall_data", out_if.data, stall_data);
                check("stall_last", out_if.last, stall_last);
            end
            stall_q  = 1'b0;
            in_fire  = in_if.valid && in_if.ready;
            out_fire = out_if.valid && out_if.ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_if.valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_o", out_if.data, e.data);
                    check("last_o", out_if.last, e.last);
                    check("tile_done_o", tile_done_o, e.last);
                    last_out = out_if.data;
                end
            end else begin
                check("tile_done_idle", tile_done_o, 0);
            end
            if (out_if.valid && !out_if.ready) begin
                stall_q    = 1'b1;
                stall_data = out_if.data;
                stall_last = out_if.last;
            end
            if (in_fire) begin
                if (m_cnt == 0) begin
                    m_act = int'(activation_i);
                    m_one = int'(one_i);
                    m_b   = int'(b_i);
                    m_c   = int'(c_i);
                    m_eps = int'(eps_mult_i);
                    m_sh  = int'(right_shift_i);
                    m_add = int'(add_i);
                    m_len = (tile_len_i == 0) ? 1 : int'(tile_len_i);
                end
                e.last = (m_cnt == m_len - 1);
                m_cnt  = e.last ? 0 : m_cnt + 1;
                for (int i = 0; i < int'(N); i++) begin
                    e.data[i*WI +: WI] = WI'(act_model(lane(in_if.data, i)));
                end
                exp_q.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int acc0;
        acc0         = n_acc;
        in_if.data   = d;
        in_if.valid  = 1'b1;
        for (int k = 0; k < 20 && n_acc == acc0; k++) tick();
        check("send_accepted", n_acc - acc0, 1);
        in_if.valid  = 1'b0;
    endtask

    task automatic drain();
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) tick();
        tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic set_gelu(input int one, input int b, input int c, input int eps,
                            input int sh, input int add);
        one_i         = GW'(one);
        b_i           = GW'(b);
        c_i           = GW'(c);
        eps_mult_i    = EMS'(eps);
        right_shift_i = EMS'(sh);
        add_i         = EMS'(add);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] beat;
        int n0;

        // Reset state
        rst_i        = 1'b1;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b0;
        activation_i = 2'd0;
        tile_len_i   = 16'd1;
        set_gelu(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        tick();
        tick();
        check("rst_valid_o", out_if.valid, 0);
        check("rst_data_o", out_if.data, 0);
        check("rst_last_o", out_if.last, 0);
        check("rst_tile_done", tile_done_o, 0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", in_if.ready, 1);
        out_if.ready = 1'b1;

        // Identity, single-beat tiles, two-register latency
        beat = pack4(-5, 0, 127, -128);
        send(beat);
        check("no_early_valid", out_if.valid, 0);
        tick();
        check("lat_valid", out_if.valid, 1);
        check("lat_data", out_if.data, beat);
        check("lat_last", out_if.last, 1);
        check("lat_tile_done", tile_done_o, 1);
        for (int k = 0; k < 3; k++) send(DW'($urandom));
        drain();

        // ReLU
        activation_i = 2'd1;
        send(pack4(-5, 7, -128, 0));
        drain();
        check("relu_vec", last_out, pack4(0, 7, 0, 0));

        // GELU code (identity when the GELU build option is off)
        activation_i = 2'd2;
        set_gelu(1, 0, 0, 1, 0, 0);
        send(pack4(100, -3, 0, 1));
        drain();
        check("gelu_unit", last_out, pack4(100, -3, 0, 1));
        set_gelu(1, 0, 0, 2, 0, 0);
        send(pack4(100, -100, 0, 1));
        drain();
`ifdef ITA_ACTIVATION_GELU_EN
        check("gelu_sat", last_out, pack4(127, -128, 0, 2));
`else
        check("gelu_off_sat", last_out, pack4(100, -100, 0, 1));
`endif
        set_gelu(0, 0, 0, 1, 0, 3);
        send(pack4(-77, 12, 0, 127));
        drain();
`ifdef ITA_ACTIVATION_GELU_EN
        check("gelu_add", last_out, pack4(3, 3, 3, 3));
`else
        check("gelu_off_add", last_out, pack4(-77, 12, 0, 127));
`endif

        // Three-beat ReLU tile with config changed after the first beat
        activation_i = 2'd1;
        tile_len_i   = 16'd3;
        send(pack4(-1, 2, -3, 4));
        activation_i = 2'd0;
        tile_len_i   = 16'd7;
        send(pack4(-10, 20, -30, 40));
        send(pack4(-50, -60, 70, 80));
        tile_len_i   = 16'd1;
        send(pack4(-9, 9, -8, 8));
        drain();
        check("next_tile_identity", last_out, pack4(-9, 9, -8, 8));

        // Backpressure across single-beat tiles with alternating configs
        tile_len_i   = 16'd1;
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        n0 = n_acc;
        for (int k = 0; k < 5; k++) begin
            in_if.data   = DW'($urandom);
            activation_i = n_acc[0] ? 2'd1 : 2'd0;
            tick();
        end
        check("bp_accepts", n_acc - n0, 2);
        check("bp_ready_low", in_if.ready, 0);
        out_if.ready = 1'b1;
        for (int k = 0; k < 20 && (n_acc - n0) < 6; k++) begin
            in_if.data   = DW'($urandom);
            activation_i = n_acc[0] ? 2'd1 : 2'd0;
            tick();
        end
        check("bp_all_accepted", n_acc - n0, 6);
        drain();

        // Reset in the middle of a four-beat tile
        activation_i = 2'd0;
        tile_len_i   = 16'd4;
        send(pack4(1, 2, 3, 4));
        in_if.data  = pack4(5, 6, 7, 8);
        in_if.valid = 1'b1;
        rst_i       = 1'b1;
        tick();
        rst_i       = 1'b0;
        in_if.valid = 1'b0;
        check("midrst_valid", out_if.valid, 0);
        activation_i = 2'd1;
        tile_len_i   = 16'd1;
        send(pack4(-9, 9, -1, 1));
        drain();
        check("post_rst_first_beat", last_out, pack4(0, 9, 0, 1));

        // Random traffic, configs and backpressure
        for (int k = 0; k < 400; k++) begin
            in_if.valid  = ($urandom_range(0, 3) != 0);
            out_if.ready = ($urandom_range(0, 3) != 0);
            in_if.data   = DW'($urandom);
            activation_i = 2'($urandom_range(0, 3));
            tile_len_i   = 16'($urandom_range(0, 4));
            set_gelu(int'($urandom_range(0, 120)) - 60, -int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 20)) - 10,
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
